dco_freq_lock_ctrl: RTL and testbench

- Consumer of the frequency-ratio measurement. Reads the ring-oscillator edge count C_freq, which is latched once per AVG_CYCLES F_clk cycles.
- Drives the DCO control word so that C_freq converges to a programmed target, then holds it there.
- Coarse acquisition is a successive-approximation (SAR) search over the DCO code; fine acquisition is ±1 tracking with a lock detector.
- Sits between the frequency-ratio measurer and the ring-oscillator DCO. It owns the measurer's Reset via meas_rst.

---
 rtl/dco_freq_lock_ctrl_if.sv | 30 +++
 rtl/dco_freq_lock_ctrl.sv | 146 ++++++++++++++
 tb/tb_dco_freq_lock_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dco_freq_lock_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : dco_freq_lock_ctrl_if                                   |
// | Brief    : Control/measurement bundle between lock controller,     |
// |            frequency measurer and DCO.                             |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface dco_freq_lock_ctrl_if #(
  parameter int CODE_W = 8
);
  logic              En;
  logic              start;
  logic [31:0]       target_freq;
  logic [31:0]       C_freq;
  logic [CODE_W-1:0] dco_code;
  logic              meas_rst;
  logic              sar_done;
  logic              locked;

  modport master (
    input  En, start, target_freq, C_freq,
    output dco_code, meas_rst, sar_done, locked
  );

  modport slave (
    output En, start, target_freq, C_freq,
    input  dco_code, meas_rst, sar_done, locked
  );
endinterface
`default_nettype wire

// File: rtl/dco_freq_lock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : dco_freq_lock_ctrl                                      |
// | Brief    : SAR coarse search then +/-1 tracking of a DCO code so   |
// |            the measured ring count settles on a target.            |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module dco_freq_lock_ctrl #(
  parameter int CODE_W     = 8,
  parameter int AVG_CYCLES = 100,
  parameter int WAIT_CYC   = AVG_CYCLES + 2,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4
) (
  input  wire logic            F_clk,
  input  wire logic            combReset,
  dco_freq_lock_ctrl_if.master bus
);

  localparam int BIT_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int WCNT_W = $clog2(WAIT_CYC + 1);
  localparam int LCNT_W = $clog2(LOCK_CNT + 1);

  localparam logic [BIT_W-1:0]  c_bitTop   = BIT_W'(CODE_W - 1);
  localparam logic [WCNT_W-1:0] c_waitLast = WCNT_W'(WAIT_CYC - 1);
  localparam logic [LCNT_W-1:0] c_lockMax  = LCNT_W'(LOCK_CNT);
  localparam logic signed [32:0] c_tolPos  = 33'(TOL);
  localparam logic signed [32:0] c_tolNeg  = -c_tolPos;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_APPLY = 3'd1,
    S_WAIT  = 3'd2,
    S_CMP   = 3'd3,
    T_APPLY = 3'd4,
    T_WAIT  = 3'd5,
    T_CMP   = 3'd6
  } state_t;

  state_t              r_state;
  logic [CODE_W-1:0]   r_dcoCode;
  logic                r_measRst;
  logic                r_sarDone;
  logic                r_locked;
  logic [BIT_W-1:0]    r_bitIdx;
  logic [WCNT_W-1:0]   r_waitCnt;
  logic [LCNT_W-1:0]   r_lockCnt;

  logic signed [32:0]  w_err;
  logic                w_cZero;
  logic                w_sarFast;
  logic                w_tooFast;
  logic                w_tooSlow;
  logic [BIT_W-1:0]    w_bitDec;
  logic [CODE_W-1:0]   w_sarCode;
  logic [LCNT_W-1:0]   w_lockInc;

  // Zero-extend both operands so the difference never overflows.
  assign w_err     = $signed({1'b0, bus.C_freq}) - $signed({1'b0, bus.target_freq});
  // A zero count means the ring stalled or no window has latched yet: treat as slow.
  assign w_cZero   = (bus.C_freq == 32'd0);
  assign w_sarFast = !w_cZero && (w_err > 33'sd0);
  assign w_tooFast = !w_cZero && (w_err > c_tolPos);
  assign w_tooSlow = w_cZero || (w_err < c_tolNeg);
  assign w_bitDec  = r_bitIdx - 1'b1;
  assign w_lockInc = (r_lockCnt == c_lockMax) ? r_lockCnt : r_lockCnt + 1'b1;

  always_comb begin
    w_sarCode = r_dcoCode;
    if (w_sarFast) w_sarCode[r_bitIdx] = 1'b0;
    if (r_bitIdx != '0) w_sarCode[w_bitDec] = 1'b1;
  end

  always_ff @(posedge F_clk or posedge combReset) begin
    if (combReset) begin
      r_state   <= IDLE;
      r_dcoCode <= '0;
      r_measRst <= 1'b0;
      r_sarDone <= 1'b0;
      r_locked  <= 1'b0;
      r_bitIdx  <= c_bitTop;
      r_waitCnt <= '0;
      r_lockCnt <= '0;
    end else if (bus.En) begin
      if (bus.start) begin
        r_state   <= S_APPLY;
        r_bitIdx  <= c_bitTop;
        r_dcoCode <= {1'b1, {(CODE_W-1){1'b0}}};
        r_measRst <= 1'b1;
        r_sarDone <= 1'b0;
        r_locked  <= 1'b0;
        r_lockCnt <= '0;
      end else begin
        case (r_state)
          IDLE: begin
          end
          S_APPLY, T_APPLY: begin
            r_measRst <= 1'b0;
            r_waitCnt <= '0;
            r_state   <= (r_state == S_APPLY) ? S_WAIT : T_WAIT;
          end
          S_WAIT, T_WAIT: begin
            r_waitCnt <= r_waitCnt + 1'b1;
            if (r_waitCnt == c_waitLast)
              r_state <= (r_state == S_WAIT) ? S_CMP : T_CMP;
          end
          S_CMP: begin
            r_dcoCode <= w_sarCode;
            r_measRst <= 1'b1;
            if (r_bitIdx != '0) begin
              r_bitIdx <= w_bitDec;
              r_state  <= S_APPLY;
            end else begin
              r_sarDone <= 1'b1;
              r_state   <= T_APPLY;
            end
          end
          T_CMP: begin
            r_measRst <= 1'b1;
            r_state   <= T_APPLY;
            if (w_tooFast) begin
              if (r_dcoCode != '0) r_dcoCode <= r_dcoCode - 1'b1;
              r_lockCnt <= '0;
              r_locked  <= 1'b0;
            end else if (w_tooSlow) begin
              if (!(&r_dcoCode)) r_dcoCode <= r_dcoCode + 1'b1;
              r_lockCnt <= '0;
              r_locked  <= 1'b0;
            end else begin
              r_lockCnt <= w_lockInc;
              r_locked  <= (w_lockInc == c_lockMax);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dco_code = r_dcoCode;
  assign bus.meas_rst = r_measRst;
  assign bus.sar_done = r_sarDone;
  assign bus.locked   = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_dco_freq_lock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_dco_freq_lock_ctrl                                   |
// | Brief    : Directed bench with a ring model C_freq = 2*code+offset |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_dco_freq_lock_ctrl;

  localparam int STEP    = 104;
  localparam int SAR_CYC = 8 * STEP;
  localparam int LOCK_CY = 4 * STEP;

  logic F_clk     = 1'b0;
  logic combReset = 1'b0;
  logic refresh   = 1'b0;
  int   offset    = 0;
  int   errors    = 0;
  int   checks    = 0;

  dco_freq_lock_ctrl_if #(.CODE_W(8)) bus ();

  dco_freq_lock_ctrl dut (
    .F_clk     (F_clk),
    .combReset (combReset),
    .bus       (bus.master)
  );

  always #5 F_clk = ~F_clk;

  // Ring model: a fresh count is latched whenever the measurer is reset.
  always @(negedge F_clk)
    if (combReset || bus.meas_rst || refresh)
      bus.C_freq = 32'(2 * int'(bus.dco_code) + offset);

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge F_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    combReset       = 1'b1;
    bus.En          = 1'b1;
    bus.start       = 1'b0;
    bus.target_freq = 32'd400;
    tick(3);
    checks++; if (bus.dco_code !== 8'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", bus.dco_code); end
    checks++; if (bus.meas_rst !== 1'b0) begin errors++; $display("FAIL reset_meas_rst: got %b want 0", bus.meas_rst); end
    checks++; if (bus.sar_done !== 1'b0) begin errors++; $display("FAIL reset_sar_done: got %b want 0", bus.sar_done); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
    combReset = 1'b0;
    tick(5);
    checks++; if (bus.dco_code !== 8'd0 || bus.meas_rst !== 1'b0) begin errors++; $display("FAIL idle_hold: code=%0d meas_rst=%b want 0/0", bus.dco_code, bus.meas_rst); end
  endtask

  task automatic test_sar_lock();
    logic [7:0] seq [8];
    int rstHigh = 0;
    seq = '{8'd128, 8'd192, 8'd224, 8'd208, 8'd200, 8'd204, 8'd202, 8'd201};
    pulse_start();
    for (int k = 0; k <= SAR_CYC; k++) begin
      if (bus.meas_rst === 1'b1) rstHigh++;
      if (k % STEP == 0 && k < SAR_CYC) begin
        checks++;
        if (bus.dco_code !== seq[k/STEP] || bus.meas_rst !== 1'b1) begin
          errors++;
          $display("FAIL sar_trial%0d: code=%0d meas_rst=%b want code=%0d meas_rst=1", k/STEP, bus.dco_code, bus.meas_rst, seq[k/STEP]);
        end
      end
      if (k == SAR_CYC - 1) begin
        checks++; if (bus.sar_done !== 1'b0) begin errors++; $display("FAIL sar_done_early: got %b want 0", bus.sar_done); end
      end
      if (k < SAR_CYC) tick(1);
    end
    checks++; if (bus.sar_done !== 1'b1 || bus.dco_code !== 8'd200) begin errors++; $display("FAIL sar_result: done=%b code=%0d want 1/200", bus.sar_done, bus.dco_code); end
    checks++; if (rstHigh != 9) begin errors++; $display("FAIL sar_meas_rst_pulses: got %0d want 9", rstHigh); end
    tick(LOCK_CY - 1);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", bus.locked); end
    tick(1);
    checks++; if (bus.locked !== 1'b1 || bus.dco_code !== 8'd200) begin errors++; $display("FAIL lock_on_time: locked=%b code=%0d want 1/200", bus.locked, bus.dco_code); end
  endtask

  task automatic test_restart_locked();
    pulse_start();
    checks++; if (bus.locked !== 1'b0 || bus.sar_done !== 1'b0) begin errors++; $display("FAIL restart_flags: locked=%b done=%b want 0/0", bus.locked, bus.sar_done); end
    checks++; if (bus.dco_code !== 8'h80 || bus.meas_rst !== 1'b1) begin errors++; $display("FAIL restart_code: code=%0h meas_rst=%b want 80/1", bus.dco_code, bus.meas_rst); end
    tick(SAR_CYC);
    checks++; if (bus.sar_done !== 1'b1 || bus.dco_code !== 8'd200) begin errors++; $display("FAIL restart_converge: done=%b code=%0d want 1/200", bus.sar_done, bus.dco_code); end
    tick(LOCK_CY);
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL restart_relock: got %b want 1", bus.locked); end
  endtask

  task automatic test_detune();
    int n;
    offset  = 6;
    refresh = 1'b1;
    @(negedge F_clk);
    #1 refresh = 1'b0;
    n = 0;
    while (n < 120 && bus.dco_code === 8'd200) begin tick(1); n++; end
    checks++; if (bus.dco_code !== 8'd199 || bus.locked !== 1'b0) begin errors++; $display("FAIL detune_step1: code=%0d locked=%b want 199/0", bus.dco_code, bus.locked); end
    n = 0;
    while (n < 120 && bus.dco_code === 8'd199) begin tick(1); n++; end
    checks++; if (bus.dco_code !== 8'd198) begin errors++; $display("FAIL detune_step2: code=%0d want 198", bus.dco_code); end
    n = 0;
    while (n < 600 && bus.locked !== 1'b1) begin tick(1); n++; end
    checks++; if (bus.locked !== 1'b1 || n != LOCK_CY || bus.dco_code !== 8'd198) begin errors++; $display("FAIL detune_relock: locked=%b cycles=%0d code=%0d want 1/%0d/198", bus.locked, n, bus.dco_code, LOCK_CY); end
    offset = 0;
  endtask

  task automatic test_enable();
    logic moved = 1'b0;
    pulse_start();
    tick(41);
    bus.En = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.dco_code !== 8'd128 || bus.meas_rst !== 1'b0 || bus.sar_done !== 1'b0) moved = 1'b1;
    end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL en_freeze: outputs moved while En=0, code=%0d", bus.dco_code); end
    bus.En = 1'b1;
    tick(62);
    checks++; if (bus.dco_code !== 8'd128 || bus.meas_rst !== 1'b0) begin errors++; $display("FAIL en_resume_pre: code=%0d meas_rst=%b want 128/0", bus.dco_code, bus.meas_rst); end
    tick(1);
    checks++; if (bus.dco_code !== 8'd192 || bus.meas_rst !== 1'b1) begin errors++; $display("FAIL en_resume_cmp: code=%0d meas_rst=%b want 192/1", bus.dco_code, bus.meas_rst); end
    bus.En = 1'b0;
    tick(5);
    checks++; if (bus.meas_rst !== 1'b1) begin errors++; $display("FAIL en_hold_meas_rst: got %b want 1", bus.meas_rst); end
    bus.En = 1'b1;
    tick(1);
    checks++; if (bus.meas_rst !== 1'b0) begin errors++; $display("FAIL en_apply_exit: got %b want 0", bus.meas_rst); end
  endtask

  task automatic test_async_reset();
    logic active = 1'b0;
    tick(20);
    #3 combReset = 1'b1;
    #1;
    checks++; if (bus.dco_code !== 8'd0 || bus.meas_rst !== 1'b0 || bus.sar_done !== 1'b0 || bus.locked !== 1'b0) begin
      errors++; $display("FAIL async_reset: code=%0d meas_rst=%b done=%b locked=%b want all 0", bus.dco_code, bus.meas_rst, bus.sar_done, bus.locked);
    end
    #2 combReset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (bus.dco_code !== 8'd0 || bus.meas_rst !== 1'b0) active = 1'b1;
    end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL post_reset_idle: activity seen, code=%0d", bus.dco_code); end
  endtask

  task automatic test_saturation();
    logic bad = 1'b0;
    int pulses = 0;
    bus.target_freq = 32'hFFFF_FFFF;
    pulse_start();
    tick(SAR_CYC);
    checks++; if (bus.sar_done !== 1'b1 || bus.dco_code !== 8'hFF) begin errors++; $display("FAIL sat_sar: done=%b code=%0h want 1/ff", bus.sar_done, bus.dco_code); end
    for (int i = 0; i < 3 * STEP + 10; i++) begin
      tick(1);
      if (bus.dco_code !== 8'hFF || bus.locked !== 1'b0) bad = 1'b1;
      if (bus.meas_rst === 1'b1) pulses++;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL sat_hold: code=%0h locked=%b want ff/0 throughout", bus.dco_code, bus.locked); end
    checks++; if (pulses != 3) begin errors++; $display("FAIL sat_tracking: meas_rst pulses=%0d want 3", pulses); end
  endtask

  initial begin
    bus.En          = 1'b1;
    bus.start       = 1'b0;
    bus.target_freq = 32'd400;
    test_reset();
    test_sar_lock();
    test_restart_locked();
    test_detune();
    test_enable();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
